// File: rtl/sevseg_scan_ctrl_if.sv
// Load channel between the byte source (UART side) and the seven-segment scan
// controller: one byte (two hex digits) per valid/ready transfer.
interface sevseg_scan_ctrl_if;
  logic       LOAD_VALID;
  logic       LOAD_READY;
  logic [7:0] LOAD_DATA;

  // Byte producer
  modport master (
    output LOAD_VALID,
    output LOAD_DATA,
    input  LOAD_READY
  );

  // Scan controller
  modport slave (
    input  LOAD_VALID,
    input  LOAD_DATA,
    output LOAD_READY
  );
endinterface

// File: rtl/sevseg_scan_ctrl.sv
// Two-digit seven-segment scan controller. A byte arrives over the load
// channel into a pending buffer, is promoted to the displayed (active) byte at
// a frame boundary or while idle, and is time-multiplexed onto SEG/SEL with a
// blanking gap after each digit and 4-bit PWM brightness. All outputs are
// registered; every next-state value is formed in one combinational block.
module sevseg_scan_ctrl #(
  parameter int DWELL_CYCLES = 6000,
  parameter int BLANK_CYCLES = 60
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                ENABLE,
  input  logic [3:0]          BRIGHT,
  sevseg_scan_ctrl_if.slave   load,
  output logic [6:0]          SEG,
  output logic                SEL,
  output logic                FRAME_TICK
);

  localparam int CNT_W = $clog2(DWELL_CYCLES) + 1;
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [3:0]       PWM_LAST   = 4'd14;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SHOW0  = 3'd1,
    BLANK0 = 3'd2,
    SHOW1  = 3'd3,
    BLANK1 = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] dwell_cnt_q, dwell_cnt_d;
  logic [3:0]       pwm_cnt_q, pwm_cnt_d;
  logic [7:0]       active_q, active_d;
  logic [7:0]       pend_q, pend_d;
  logic             pend_full_q, pend_full_d;
  logic             ready_q, ready_d;
  logic [6:0]       seg_q, seg_d;
  logic             sel_q, sel_d;
  logic             tick_q, tick_d;

  logic             frame_edge;
  logic             promote;
  logic             xfer;
  logic             pwm_on;

  // Hex nibble to segment pattern, bit order {g,f,e,d,c,b,a}, active high
  function automatic logic [6:0] hex7seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'h3F;
      4'h1:    s = 7'h06;
      4'h2:    s = 7'h5B;
      4'h3:    s = 7'h4F;
      4'h4:    s = 7'h66;
      4'h5:    s = 7'h6D;
      4'h6:    s = 7'h7D;
      4'h7:    s = 7'h07;
      4'h8:    s = 7'h7F;
      4'h9:    s = 7'h6F;
      4'hA:    s = 7'h77;
      4'hB:    s = 7'h7C;
      4'hC:    s = 7'h39;
      4'hD:    s = 7'h5E;
      4'hE:    s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  // Next-state logic: scan sequencing, buffer handshake, PWM and output decode
  always_comb begin
    // Scan sequencing; the dwell counter restarts on every state change
    state_d     = state_q;
    dwell_cnt_d = dwell_cnt_q + CNT_W'(1);
    case (state_q)
      IDLE:    if (ENABLE) state_d = SHOW0;
      SHOW0:   if (dwell_cnt_q == DWELL_LAST) state_d = BLANK0;
      BLANK0:  if (dwell_cnt_q == BLANK_LAST) state_d = SHOW1;
      SHOW1:   if (dwell_cnt_q == DWELL_LAST) state_d = BLANK1;
      BLANK1:  if (dwell_cnt_q == BLANK_LAST) state_d = SHOW0;
      default: state_d = IDLE;
    endcase
    if (!ENABLE) state_d = IDLE;
    if ((state_d != state_q) || (state_q == IDLE)) dwell_cnt_d = '0;

    // A frame starts whenever SHOW0 is entered from BLANK1 or from IDLE
    frame_edge = (state_d == SHOW0) && ((state_q == BLANK1) || (state_q == IDLE));

    // Promotion looks only at the pending flag registered before this edge,
    // so a byte accepted on a frame edge waits for the following frame.
    promote     = pend_full_q && ((state_q == IDLE) || frame_edge);
    xfer        = load.LOAD_VALID && ready_q;
    active_d    = promote ? pend_q : active_q;
    pend_d      = xfer ? load.LOAD_DATA : pend_q;
    pend_full_d = xfer || (pend_full_q && !promote);
    // READY reopens one cycle after the buffer has been emptied
    ready_d     = !xfer && !pend_full_q;

    // Free-running 0..14 PWM; BRIGHT=15 is therefore always on
    pwm_cnt_d = (pwm_cnt_q == PWM_LAST) ? 4'd0 : pwm_cnt_q + 4'd1;
    pwm_on    = (pwm_cnt_q < BRIGHT);

    // Outputs are decoded from the next state so they line up with it
    sel_d = sel_q;
    seg_d = 7'h00;
    case (state_d)
      SHOW0: begin
        sel_d = 1'b0;
        if (pwm_on) seg_d = hex7seg(active_d[3:0]);
      end
      BLANK0:  sel_d = 1'b0;
      SHOW1: begin
        sel_d = 1'b1;
        if (pwm_on) seg_d = hex7seg(active_d[7:4]);
      end
      BLANK1:  sel_d = 1'b1;
      default: sel_d = sel_q;
    endcase
    tick_d = frame_edge;
  end

  // State and registered outputs
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      dwell_cnt_q <= '0;
      pwm_cnt_q   <= 4'd0;
      active_q    <= 8'h00;
      pend_q      <= 8'h00;
      pend_full_q <= 1'b0;
      ready_q     <= 1'b1;
      seg_q       <= 7'h00;
      sel_q       <= 1'b0;
      tick_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      dwell_cnt_q <= dwell_cnt_d;
      pwm_cnt_q   <= pwm_cnt_d;
      active_q    <= active_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      ready_q     <= ready_d;
      seg_q       <= seg_d;
      sel_q       <= sel_d;
      tick_q      <= tick_d;
    end
  end

  assign load.LOAD_READY = ready_q;
  assign SEG             = seg_q;
  assign SEL             = sel_q;
  assign FRAME_TICK      = tick_q;

endmodule

// File: tb/tb_sevseg_scan_ctrl.sv
// Bench for sevseg_scan_ctrl: directed scenarios followed by random traffic,
// all compared cycle by cycle with a frame-position model of the display.
module tb_sevseg_scan_ctrl;
  localparam int D     = 8;
  localparam int B     = 2;
  localparam int FRAME = 2 * D + 2 * B;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       ENABLE;
  logic [3:0] BRIGHT;
  logic [6:0] SEG;
  logic       SEL;
  logic       FRAME_TICK;

  sevseg_scan_ctrl_if lif ();

  sevseg_scan_ctrl #(.DWELL_CYCLES(D), .BLANK_CYCLES(B)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .ENABLE     (ENABLE),
    .BRIGHT     (BRIGHT),
    .load       (lif),
    .SEG        (SEG),
    .SEL        (SEL),
    .FRAME_TICK (FRAME_TICK)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: display on/off, position within a FRAME-long frame, byte buffers
  bit         m_on;
  int         m_pos;
  logic [7:0] m_active, m_pend;
  bit         m_pend_v, m_ready, m_xfer;
  int         m_pwm;
  logic [6:0] e_seg;
  logic       e_sel, e_tick;

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    logic [6:0] t [16];
    t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
          7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    return t[n];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t observed=%0h expected=%0h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_on = 0; m_pos = 0; m_active = 8'h00; m_pend = 8'h00;
    m_pend_v = 0; m_ready = 1; m_xfer = 0; m_pwm = 0;
    e_seg = 7'h00; e_sel = 1'b0; e_tick = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs held at that edge
  task automatic model_upd();
    bit boundary, promote, pwm_on;
    if (!RST_N) begin
      model_reset();
      return;
    end
    m_xfer   = lif.LOAD_VALID && m_ready;
    boundary = ENABLE && (!m_on || m_pos == FRAME - 1);
    promote  = m_pend_v && (!m_on || boundary);
    pwm_on   = (m_pwm < int'(BRIGHT));
    m_ready  = !m_xfer && !m_pend_v;
    if (promote) begin m_active = m_pend; m_pend_v = 0; end
    if (m_xfer)  begin m_pend = lif.LOAD_DATA; m_pend_v = 1; end
    if (ENABLE) begin
      if (!m_on) begin m_on = 1; m_pos = 0; end
      else m_pos = (m_pos + 1) % FRAME;
    end else begin
      m_on = 0;
    end
    m_pwm  = (m_pwm + 1) % 15;
    e_tick = boundary;
    e_seg  = 7'h00;
    if (m_on) begin
      e_sel = (m_pos >= D + B);
      if (pwm_on && m_pos < D)
        e_seg = seg_of(m_active[3:0]);
      else if (pwm_on && m_pos >= D + B && m_pos < 2 * D + B)
        e_seg = seg_of(m_active[7:4]);
    end
  endtask

  task automatic compare();
    chk("seg",   32'(SEG),            32'(e_seg));
    chk("sel",   32'(SEL),            32'(e_sel));
    chk("tick",  32'(FRAME_TICK),     32'(e_tick));
    chk("ready", 32'(lif.LOAD_READY), 32'(m_ready));
  endtask

  task automatic step();
    @(posedge CLK);
    model_upd();
    @(negedge CLK);
    compare();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send(input logic [7:0] b);
    int k;
    lif.LOAD_VALID = 1'b1;
    lif.LOAD_DATA  = b;
    k = 0;
    do begin step(); k++; end while (!m_xfer && k < 200);
    chk("send_accept", 32'(m_xfer), 32'd1);
  endtask

  task automatic wait_pos(input int p);
    int k;
    k = 0;
    while (!(m_on && m_pos == p) && k < 100) begin step(); k++; end
    chk("wait_pos", 32'(m_on && m_pos == p), 32'd1);
  endtask

  initial begin
    model_reset();
    RST_N = 1'b0; ENABLE = 1'b1; BRIGHT = 4'd15;
    lif.LOAD_VALID = 1'b0; lif.LOAD_DATA = 8'h00;
    #23;
    chk("rst_seg",   32'(SEG),            32'h0);
    chk("rst_sel",   32'(SEL),            32'h0);
    chk("rst_tick",  32'(FRAME_TICK),     32'h0);
    chk("rst_ready", 32'(lif.LOAD_READY), 32'h1);
    @(negedge CLK);
    RST_N = 1'b1;

    // Free-running scan of 00
    run(45);

    // Load mid-SHOW1, shown from the next frame
    wait_pos(12);
    send(8'hA5);
    lif.LOAD_VALID = 1'b0;
    run(45);

    // Back-to-back bytes: second one stalls until the buffer frees
    send(8'h12);
    send(8'h34);
    lif.LOAD_VALID = 1'b0;
    run(60);

    // Reduced and zero brightness on digit 8
    send(8'h88);
    lif.LOAD_VALID = 1'b0;
    BRIGHT = 4'd4;
    run(60);
    BRIGHT = 4'd0;
    run(30);
    BRIGHT = 4'd15;

    // Disable during SHOW0, load while idle, re-enable
    wait_pos(3);
    ENABLE = 1'b0;
    run(3);
    send(8'h5C);
    lif.LOAD_VALID = 1'b0;
    run(4);
    ENABLE = 1'b1;
    run(25);

    // Asynchronous reset mid-SHOW1 with the pending buffer full
    wait_pos(12);
    send(8'h77);
    lif.LOAD_VALID = 1'b0;
    #2 RST_N = 1'b0;
    #1;
    chk("arst_seg",   32'(SEG),            32'h0);
    chk("arst_sel",   32'(SEL),            32'h0);
    chk("arst_ready", 32'(lif.LOAD_READY), 32'h1);
    model_reset();
    step();
    RST_N = 1'b1;
    run(25);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      ENABLE         = ($urandom_range(0, 99) < 97);
      if ($urandom_range(0, 99) == 0) BRIGHT = 4'($urandom_range(0, 15));
      lif.LOAD_VALID = ($urandom_range(0, 7) == 0);
      lif.LOAD_DATA  = 8'($urandom_range(0, 255));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
